// File: rtl/prog3_pkg.sv
// Shared types and constants for the program-3 match engine.
package prog3_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SCAN = 3'd2,
    WR0  = 3'd3,
    WR1  = 3'd4,
    WR2  = 3'd5,
    DONE = 3'd6
  } state_e;

  localparam int unsigned DEF_ADDR_W   = 8;
  localparam int unsigned DEF_MSG_BASE = 0;
  localparam int unsigned DEF_MSG_LEN  = 32;
  localparam int unsigned DEF_PAT_ADDR = 32;
  localparam int unsigned DEF_RES_ADDR = 33;

  localparam int unsigned PAT_W     = 5;
  localparam int unsigned IN_WIN    = 4;
  localparam int unsigned CROSS_WIN = 8;

endpackage

// File: rtl/prog3_match_engine_if.sv
// Request/done handshake plus data-memory mailbox bus for the match engine.
interface prog3_match_engine_if #(
  parameter int unsigned ADDR_W = 8
) ();
  logic              req;
  logic              done;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic              mem_wr_en;
  logic [7:0]        mem_wr_data;

  modport master (
    output req, mem_rd_data,
    input  done, busy, mem_addr, mem_wr_en, mem_wr_data
  );

  modport slave (
    input  req, mem_rd_data,
    output done, busy, mem_addr, mem_wr_en, mem_wr_data
  );
endinterface

// File: rtl/pat_window_match.sv
// Counts 5-bit pattern hits in the in-byte windows and the byte-crossing
// windows of {prev4, cur}; on the first byte only in-byte windows exist.
module pat_window_match
  import prog3_pkg::*;
(
  input  logic [11:0]      win,
  input  logic [PAT_W-1:0] pat,
  input  logic             first,
  output logic [2:0]       in_hits,
  output logic             any_hit,
  output logic [3:0]       cross_hits
);

  logic [3:0] all_hits;

  // Windows k=0..3 sit entirely in cur; k=4..7 reach into prev4.
  always_comb begin
    in_hits  = '0;
    all_hits = '0;
    for (int unsigned k = 0; k < CROSS_WIN; k++) begin
      if (win[k +: PAT_W] == pat) begin
        all_hits = all_hits + 4'd1;
        if (k < IN_WIN) in_hits = in_hits + 3'd1;
      end
    end
    any_hit    = (in_hits != '0);
    cross_hits = first ? {1'b0, in_hits} : all_hits;
  end

endmodule

// File: rtl/prog3_match_engine.sv
// Golden accelerator for program 3: reads message and pattern from data
// memory, computes ctb/cto/cts and writes them to the result mailbox.
module prog3_match_engine
  import prog3_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned MSG_BASE = DEF_MSG_BASE,
  parameter int unsigned MSG_LEN  = DEF_MSG_LEN,
  parameter int unsigned PAT_ADDR = DEF_PAT_ADDR,
  parameter int unsigned RES_ADDR = DEF_RES_ADDR
) (
  input logic                 clk,
  input logic                 rst_n,
  prog3_match_engine_if.slave bus
);

  state_e            state_q, state_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [3:0]        prev4_q, prev4_d;
  logic [7:0]        ctb_q, ctb_d, cto_q, cto_d, cts_q, cts_d;
  logic              done_q, done_d;

  logic [2:0] in_hits;
  logic       any_hit;
  logic [3:0] cross_hits;

  pat_window_match u_match (
    .win        ({prev4_q, bus.mem_rd_data}),
    .pat        (pat_q),
    .first      (idx_q == '0),
    .in_hits    (in_hits),
    .any_hit    (any_hit),
    .cross_hits (cross_hits)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    prev4_d = prev4_q;
    ctb_d   = ctb_q;
    cto_d   = cto_q;
    cts_d   = cts_q;
    case (state_q)
      IDLE: if (bus.req) state_d = LOAD;
      LOAD: begin
        pat_d   = bus.mem_rd_data[PAT_W-1:0];
        idx_d   = '0;
        prev4_d = '0;
        ctb_d   = '0;
        cto_d   = '0;
        cts_d   = '0;
        state_d = SCAN;
      end
      SCAN: begin
        ctb_d   = ctb_q + 8'(in_hits);
        cto_d   = cto_q + 8'(any_hit);
        cts_d   = cts_q + 8'(cross_hits);
        prev4_d = bus.mem_rd_data[3:0];
        idx_d   = idx_q + ADDR_W'(1);
        if (idx_q == ADDR_W'(MSG_LEN - 1)) state_d = WR0;
      end
      WR0:  state_d = WR1;
      WR1:  state_d = WR2;
      WR2:  state_d = DONE;
      DONE: if (bus.req) state_d = LOAD;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      idx_q   <= '0;
      prev4_q <= '0;
      ctb_q   <= '0;
      cto_q   <= '0;
      cts_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      prev4_q <= prev4_d;
      ctb_q   <= ctb_d;
      cto_q   <= cto_d;
      cts_q   <= cts_d;
      done_q  <= done_d;
    end
  end

  // Memory strobes decode straight from the state register so reset kills them at once.
  always_comb begin
    bus.mem_addr    = '0;
    bus.mem_wr_en   = 1'b0;
    bus.mem_wr_data = '0;
    case (state_q)
      LOAD: bus.mem_addr = ADDR_W'(PAT_ADDR);
      SCAN: bus.mem_addr = ADDR_W'(MSG_BASE) + idx_q;
      WR0: begin
        bus.mem_addr    = ADDR_W'(RES_ADDR);
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = ctb_q;
      end
      WR1: begin
        bus.mem_addr    = ADDR_W'(RES_ADDR + 1);
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = cto_q;
      end
      WR2: begin
        bus.mem_addr    = ADDR_W'(RES_ADDR + 2);
        bus.mem_wr_en   = 1'b1;
        bus.mem_wr_data = cts_q;
      end
      default: ;
    endcase
  end

  assign bus.done = done_q;
  assign bus.busy = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_prog3_match_engine.sv
// Randomized self-checking bench for prog3_match_engine against a bit-string window model.
module tb_prog3_match_engine;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  prog3_match_engine_if #(.ADDR_W(8)) bus ();

  prog3_match_engine #(
    .ADDR_W   (8),
    .MSG_BASE (0),
    .MSG_LEN  (32),
    .PAT_ADDR (32),
    .RES_ADDR (33)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] msg [32];
  logic [7:0] pat_byte;
  logic [7:0] res [3];
  int         wr_cnt    = 0;
  int         stray_cnt = 0;
  int         n_checks  = 0;
  int         n_fail    = 0;

  always_comb begin
    if (bus.mem_addr < 8'd32)       bus.mem_rd_data = msg[bus.mem_addr[4:0]];
    else if (bus.mem_addr == 8'd32) bus.mem_rd_data = pat_byte;
    else                            bus.mem_rd_data = 8'h00;
  end

  always @(posedge clk) begin
    if (bus.mem_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      if (bus.mem_addr >= 8'd33 && bus.mem_addr <= 8'd35)
        res[int'(bus.mem_addr) - 33] <= bus.mem_wr_data;
      else
        stray_cnt <= stray_cnt + 1;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Message as one 256-bit string (byte 0 on top); every 5-bit window is a cts window,
  // those not straddling a byte boundary also count for ctb/cto.
  function automatic void model(output int ctb, output int cto, output int cts);
    logic [255:0] s;
    bit           hit [32];
    ctb = 0; cto = 0; cts = 0;
    for (int i = 0; i < 32; i++) begin
      s[255 - 8*i -: 8] = msg[i];
      hit[i] = 1'b0;
    end
    for (int j = 0; j <= 251; j++) begin
      if (s[j +: 5] == pat_byte[4:0]) begin
        cts++;
        if ((j % 8) < 4) begin
          ctb++;
          hit[(255 - j) / 8] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 32; i++) if (hit[i]) cto++;
  endfunction

  task automatic run_job(input string tag, input bit mid_req);
    int lat, wr0, stray0, e_ctb, e_cto, e_cts;
    model(e_ctb, e_cto, e_cts);
    wr0    = wr_cnt;
    stray0 = stray_cnt;
    @(negedge clk) bus.req = 1'b1;
    @(negedge clk) bus.req = 1'b0;
    check({tag, ":done_clr"}, int'(bus.done), 0);
    check({tag, ":busy"}, int'(bus.busy), 1);
    lat = 0;
    while (!bus.done && lat < 100) begin
      @(negedge clk);
      lat++;
      bus.req = (mid_req && lat == 10) ? 1'b1 : 1'b0;
    end
    bus.req = 1'b0;
    check({tag, ":latency"}, lat, 36);
    check({tag, ":busy_end"}, int'(bus.busy), 0);
    check({tag, ":ctb"}, int'(res[0]), e_ctb);
    check({tag, ":cto"}, int'(res[1]), e_cto);
    check({tag, ":cts"}, int'(res[2]), e_cts);
    check({tag, ":writes"}, wr_cnt - wr0, 3);
    check({tag, ":stray"}, stray_cnt - stray0, 0);
  endtask

  task automatic fill(input logic [7:0] b, input logic [7:0] p);
    for (int i = 0; i < 32; i++) msg[i] = b;
    pat_byte = p;
  endtask

  initial begin
    int wr0;
    rst_n   = 1'b0;
    bus.req = 1'b0;
    fill(8'h00, 8'h00);
    #1;
    check("rst:done", int'(bus.done), 0);
    check("rst:busy", int'(bus.busy), 0);
    check("rst:wr_en", int'(bus.mem_wr_en), 0);
    check("rst:addr", int'(bus.mem_addr), 0);
    check("rst:wdata", int'(bus.mem_wr_data), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    fill(8'h00, 8'h00);
    run_job("zeros", 1'b0);
    check("zeros:ctb_abs", int'(res[0]), 128);
    check("zeros:cto_abs", int'(res[1]), 32);
    check("zeros:cts_abs", int'(res[2]), 252);

    fill(8'h55, 8'h15);
    run_job("x55", 1'b0);
    check("x55:ctb_abs", int'(res[0]), 64);
    check("x55:cto_abs", int'(res[1]), 32);
    check("x55:cts_abs", int'(res[2]), 126);

    fill(8'h01, 8'h10);
    run_job("x01", 1'b0);
    check("x01:ctb_abs", int'(res[0]), 0);
    check("x01:cto_abs", int'(res[1]), 0);
    check("x01:cts_abs", int'(res[2]), 31);

    for (int s = 0; s < 50; s++) begin
      for (int i = 0; i < 32; i++) msg[i] = 8'($urandom);
      pat_byte = 8'($urandom);
      // Low-entropy bytes keep hit counts high on some seeds.
      if (s % 5 == 0) for (int i = 0; i < 32; i++) msg[i] = msg[i] & 8'h21;
      run_job($sformatf("rnd%0d", s), (s % 7) == 3);
    end

    fill(8'h00, 8'h00);
    run_job("again1", 1'b0);
    run_job("again2", 1'b0);

    // Reset in the middle of SCAN must abort without any mailbox write.
    for (int i = 0; i < 32; i++) msg[i] = 8'($urandom);
    pat_byte = 8'($urandom);
    wr0 = wr_cnt;
    @(negedge clk) bus.req = 1'b1;
    @(negedge clk) bus.req = 1'b0;
    repeat (15) @(negedge clk);
    check("abort:busy_pre", int'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort:done", int'(bus.done), 0);
    check("abort:wr_en", int'(bus.mem_wr_en), 0);
    check("abort:busy", int'(bus.busy), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("abort:no_writes", wr_cnt - wr0, 0);
    check("abort:idle_done", int'(bus.done), 0);
    run_job("post_abort", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
